// File: rtl/vec_mul_sequencer.sv
// Sequencing controller for the vector-multiply datapath: weight select/reload,
// UB read streaming and pipeline-aligned result-SRAM writes for one block per start.
module vec_mul_sequencer #(
    parameter int ADDRESSSIZE  = 10,
    parameter int PIPE_LATENCY = 33
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [ADDRESSSIZE-1:0] num_vec,
    input  logic [ADDRESSSIZE-1:0] src_base,
    input  logic [ADDRESSSIZE-1:0] dst_base,
    input  logic [1:0]             weight_slot,
    output logic [1:0]             weight_addr,
    output logic                   weight_reload,
    output logic                   ub_rd_en,
    output logic [ADDRESSSIZE-1:0] ub_addr,
    output logic                   res_we,
    output logic [ADDRESSSIZE-1:0] res_addr,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WSEL,
        S_WLOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDRESSSIZE-1:0]  num_q, num_d;
    logic [ADDRESSSIZE-1:0]  src_q, src_d;
    logic [ADDRESSSIZE-1:0]  dst_q, dst_d;
    logic [1:0]              slot_q, slot_d;
    logic [ADDRESSSIZE-1:0]  rd_q, rd_d;
    logic [ADDRESSSIZE-1:0]  wr_q, wr_d;
    logic [PIPE_LATENCY-1:0] pipe_q, pipe_d;

    // All strobes decode registered state, so start never reaches an output combinationally.
    assign weight_addr   = slot_q;
    assign weight_reload = (state_q == S_WLOAD);
    assign ub_rd_en      = (state_q == S_STREAM);
    assign ub_addr       = ub_rd_en ? (src_q + rd_q) : '0;
    assign res_we        = pipe_q[PIPE_LATENCY-1];
    assign res_addr      = res_we ? (dst_q + wr_q) : '0;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        src_d   = src_q;
        dst_d   = dst_q;
        slot_d  = slot_q;
        rd_d    = rd_q;
        wr_d    = res_we ? (wr_q + 1'b1) : wr_q;

        pipe_d[0] = ub_rd_en;
        for (int i = 1; i < PIPE_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d   = num_vec;
                    src_d   = src_base;
                    dst_d   = dst_base;
                    slot_d  = weight_slot;
                    rd_d    = '0;
                    wr_d    = '0;
                    state_d = (num_vec == '0) ? S_DONE : S_WSEL;
                end
            end
            S_WSEL:  state_d = S_WLOAD;
            S_WLOAD: state_d = S_STREAM;
            S_STREAM: begin
                rd_d = rd_q + 1'b1;
                if (rd_q == num_q - 1'b1) begin
                    state_d = S_DRAIN;
                end
            end
            // Writes retire in order, so the last one is the one at index num_q-1.
            S_DRAIN: begin
                if (res_we && (wr_q == num_q - 1'b1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            slot_q  <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            slot_q  <= slot_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            pipe_q  <= pipe_d;
        end
    end

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Scoreboard bench for vec_mul_sequencer: the driver queues expected strobes with
// their cycle numbers, a negedge monitor pops and compares whatever the DUT emits.
module tb_vec_mul_sequencer;

    localparam int AS = 10;
    localparam int L  = 33;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [AS-1:0] num_vec, src_base, dst_base;
    logic [1:0]    weight_slot;
    logic [1:0]    weight_addr;
    logic          weight_reload, ub_rd_en, res_we, busy, done;
    logic [AS-1:0] ub_addr, res_addr;

    vec_mul_sequencer #(.ADDRESSSIZE(AS), .PIPE_LATENCY(L)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .num_vec(num_vec), .src_base(src_base), .dst_base(dst_base),
        .weight_slot(weight_slot), .weight_addr(weight_addr),
        .weight_reload(weight_reload), .ub_rd_en(ub_rd_en), .ub_addr(ub_addr),
        .res_we(res_we), .res_addr(res_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        int a;
    } ev_t;

    ev_t   q[4][$];
    string nm[4] = '{"weight_reload", "ub_read", "res_write", "done"};
    bit    exp_busy[0:8191];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [3:0] sig;
        int         adr[4];
        ev_t        e;
        if (!rstn) begin
            chk("reset_outputs", int'({weight_addr, weight_reload, ub_rd_en, ub_addr,
                                       res_we, res_addr, busy, done}), 0);
        end else begin
            sig    = {done, res_we, ub_rd_en, weight_reload};
            adr[0] = int'(weight_addr);
            adr[1] = int'(ub_addr);
            adr[2] = int'(res_addr);
            adr[3] = 0;
            for (int k = 0; k < 4; k++) begin
                if (sig[k]) begin
                    if (q[k].size() == 0) begin
                        chk({nm[k], "_unexpected"}, 1, 0);
                    end else begin
                        e = q[k].pop_front();
                        chk({nm[k], "_cycle"}, cyc, e.c);
                        chk({nm[k], "_addr"}, adr[k], e.a);
                    end
                end else if (q[k].size() > 0 && q[k][0].c <= cyc) begin
                    e = q[k].pop_front();
                    chk({nm[k], "_missing"}, 0, 1);
                end
            end
            chk("busy", int'(busy), int'(exp_busy[cyc]));
        end
    end

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives a one-cycle start pulse; when accept is set, the expected strobes are queued.
    task automatic issue(input int n, input int src, input int dst, input int slot, input bit accept);
        int t;
        t           = cyc;
        num_vec     = AS'(n);
        src_base    = AS'(src);
        dst_base    = AS'(dst);
        weight_slot = 2'(slot);
        start       = 1'b1;
        if (accept) begin
            if (n == 0) begin
                q[3].push_back('{t + 1, 0});
                exp_busy[t + 1] = 1'b1;
            end else begin
                q[0].push_back('{t + 2, slot});
                for (int i = 0; i < n; i++) begin
                    q[1].push_back('{t + 3 + i, (src + i) % 1024});
                    q[2].push_back('{t + 3 + L + i, (dst + i) % 1024});
                end
                q[3].push_back('{t + 3 + n + L, 0});
                for (int c = t + 1; c <= t + 3 + n + L; c++) exp_busy[c] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int t;
        rstn = 1'b0; start = 1'b0;
        num_vec = '0; src_base = '0; dst_base = '0; weight_slot = '0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_outputs", int'({weight_addr, weight_reload, ub_rd_en, ub_addr,
                                  res_we, res_addr, busy, done}), 0);

        // Nominal block with starts at cycle 5 and in the DONE cycle that must be ignored.
        t = cyc;
        issue(4, 'h010, 'h020, 2, 1'b1);
        wait_to(t + 5);
        issue(9, 'h100, 'h200, 1, 1'b0);
        wait_to(t + 3 + 4 + L);
        issue(7, 'h005, 'h006, 3, 1'b0);

        // First IDLE cycle after done: accepted, and exercises address wrap.
        t = cyc;
        issue(3, 1022, 1023, 1, 1'b1);
        wait_to(t + 4 + 3 + L);

        // Zero-length block, followed immediately by the next start.
        t = cyc;
        issue(0, 'h050, 'h060, 3, 1'b1);
        wait_to(t + 2);

        // Reset in the middle of STREAM drops remaining reads, writes and done.
        t = cyc;
        issue(4, 'h010, 'h020, 2, 1'b1);
        wait_to(t + 4);
        rstn = 1'b0;
        for (int k = 1; k < 4; k++) q[k].delete();
        for (int c = t + 4; c <= t + 3 + 4 + L; c++) exp_busy[c] = 1'b0;
        wait_to(t + 6);
        rstn = 1'b1;
        wait_to(t + 50);

        t = cyc;
        issue(4, 'h010, 'h020, 2, 1'b1);
        wait_to(t + 4 + 4 + L + 5);

        chk("pending_expectations", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
